// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: N-digit packed-BCD counter with built-in prescaler,
// up/down stepping, synchronous clear and clamped parallel load.
// Optional build macro BCD_COUNTER_SATURATE_EN: hold at all-9s / all-0s
// instead of wrapping; carry then marks arrival at the limit.
module bcd_counter_ndigit #(
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned PRESCALE   = 5000000,
  parameter int unsigned PRESCALE_W = 30
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   out,
  output logic                  tick,
  output logic                  carry
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [W-1:0]          count_q, count_d;
  logic                  carry_q, carry_d;
  logic [W-1:0]          up_val, dn_val, ld_val;
  logic                  up_wrap, dn_wrap;
  logic [3:0]            dig, ldig;

  assign tick  = enable & (presc_q == PS_LAST);
  assign out   = count_q;
  assign carry = carry_q;

  // Prescaler: free-runs 0..PRESCALE-1 while enabled, restarted by clear.
  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Candidate up/down/load values; up_wrap/dn_wrap double as the running
  // carry/borrow and end up set only when every digit was 9 / 0.
  always_comb begin
    up_val  = count_q;
    dn_val  = count_q;
    ld_val  = '0;
    up_wrap = 1'b1;
    dn_wrap = 1'b1;
    dig     = '0;
    ldig    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (up_wrap) begin
        if (dig == 4'd9) begin
          up_val[4*i +: 4] = 4'd0;
        end else begin
          up_val[4*i +: 4] = dig + 4'd1;
          up_wrap          = 1'b0;
        end
      end
      if (dn_wrap) begin
        if (dig == 4'd0) begin
          dn_val[4*i +: 4] = 4'd9;
        end else begin
          dn_val[4*i +: 4] = dig - 4'd1;
          dn_wrap          = 1'b0;
        end
      end
      ldig = load_value[4*i +: 4];
      ld_val[4*i +: 4] = (ldig > 4'd9) ? 4'd9 : ldig;
    end
  end

  // Count next-state: clear > load > step > hold; carry only on a limit step.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = ld_val;
    end else if (tick) begin
`ifdef BCD_COUNTER_SATURATE_EN
      if (up_down) begin
        if (!up_wrap) begin
          count_d = up_val;
          carry_d = (up_val == ALL_NINES);
        end
      end else begin
        if (!dn_wrap) begin
          count_d = dn_val;
          carry_d = (dn_val == '0);
        end
      end
`else
      count_d = up_down ? up_val : dn_val;
      carry_d = up_down ? up_wrap : dn_wrap;
`endif
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      presc_q <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Self-checking bench for bcd_counter_ndigit: a decimal-integer model checks
// a PRESCALE=4 and a PRESCALE=1 instance every cycle; directed literal checks
// pin the model. Honours BCD_COUNTER_SATURATE_EN when defined.
module tb_bcd_counter_ndigit;

`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int MAXV = 99;

  typedef struct packed {
    int   val;
    int   presc;
    logic carry;
  } mstate_t;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1, en = 1'b0, ud = 1'b1, clr = 1'b0, ld = 1'b0;
  logic [7:0] lv = '0;
  logic [7:0] out4, out1;
  logic       tick4, tick1, carry4, carry1;
  bit         armed = 1'b0;
  int         errors = 0;
  int         checks = 0;
  mstate_t    m4 = '0;
  mstate_t    m1 = '0;

  always #5 clk_in = ~clk_in;

  bcd_counter_ndigit #(.DIGITS(2), .PRESCALE(4), .PRESCALE_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst), .enable(en), .up_down(ud), .clear(clr),
    .load(ld), .load_value(lv), .out(out4), .tick(tick4), .carry(carry4)
  );

  bcd_counter_ndigit #(.DIGITS(2), .PRESCALE(1), .PRESCALE_W(8)) dut1 (
    .clk_in(clk_in), .rst_in(rst), .enable(en), .up_down(ud), .clear(clr),
    .load(ld), .load_value(lv), .out(out1), .tick(tick1), .carry(carry1)
  );

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(logic [7:0] b);
    int hi, lo;
    hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic mstate_t model_next(mstate_t s, int ps, logic r, logic e,
                                         logic u, logic c, logic l, logic [7:0] v);
    mstate_t n;
    logic    tk;
    n = s;
    n.carry = 1'b0;
    tk = e && (s.presc == ps - 1);
    if (r || c) begin
      n.val = 0;
      n.presc = 0;
      return n;
    end
    if (e) n.presc = (s.presc + 1) % ps;
    if (l) begin
      n.val = clamp_val(v);
    end else if (tk) begin
      if (u) begin
        if (s.val == MAXV) begin
          n.val   = SAT ? MAXV : 0;
          n.carry = !SAT;
        end else begin
          n.val   = s.val + 1;
          n.carry = SAT && (n.val == MAXV);
        end
      end else begin
        if (s.val == 0) begin
          n.val   = SAT ? 0 : MAXV;
          n.carry = !SAT;
        end else begin
          n.val   = s.val - 1;
          n.carry = SAT && (n.val == 0);
        end
      end
    end
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on every active edge.
  always @(posedge clk_in) begin
    m4 <= model_next(m4, 4, rst, en, ud, clr, ld, lv);
    m1 <= model_next(m1, 1, rst, en, ud, clr, ld, lv);
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk_in) begin
    if (armed) begin
      check("out_p4",   32'(out4),   32'(to_bcd(m4.val)));
      check("carry_p4", 32'(carry4), 32'(m4.carry));
      check("tick_p4",  32'(tick4),  32'(en && (m4.presc == 3)));
      check("out_p1",   32'(out1),   32'(to_bcd(m1.val)));
      check("carry_p1", 32'(carry1), 32'(m1.carry));
      check("tick_p1",  32'(tick1),  32'(en));
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!tick4 && n < 8) begin
      cyc(1);
      n++;
    end
    check("tick_timeout", 32'(tick4), 32'd1);
  endtask

  task automatic to_step();
    wait_tick();
    cyc(1);
  endtask

  initial begin
    int ncarry;
    cyc(1);
    armed = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("reset_out", 32'(out4), 32'h00);

    // Reset mid-count at 37, then first step 4 edges after release.
    en = 1'b1; ud = 1'b1; ld = 1'b1; lv = 8'h37;
    cyc(1);
    ld = 1'b0;
    cyc(2);
    check("load37", 32'(out4), 32'h37);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_out", 32'(out4), 32'h00);
    check("rst_carry", 32'(carry4), 32'd0);
    check("rst_tick", 32'(tick4), 32'd0);
    cyc(3);
    check("first_tick", 32'(tick4), 32'd1);
    check("pre_step_out", 32'(out4), 32'h00);
    cyc(1);
    check("first_step", 32'(out4), 32'h01);

    // Full up sweep from 00: one carry, when out returns to 00.
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    ncarry = 0;
    for (int k = 0; k < 400; k++) begin
      cyc(1);
      if (carry4) begin
        ncarry++;
        check("carry_at_00", 32'(out4), 32'h00);
      end
    end
    check("carry_count", 32'(ncarry), 32'd1);
    check("sweep_end", 32'(out4), 32'h00);

    // Down steps: 00 -> 99 with borrow, 10 -> 09 without.
    ud = 1'b0; ld = 1'b1; lv = 8'h00;
    cyc(1);
    ld = 1'b0;
    to_step();
    check("dn_wrap_out", 32'(out4), 32'h99);
    check("dn_wrap_carry", 32'(carry4), 32'd1);
    ld = 1'b1; lv = 8'h10;
    cyc(1);
    ld = 1'b0;
    to_step();
    check("dn_10_out", 32'(out4), 32'h09);
    check("dn_10_carry", 32'(carry4), 32'd0);

    // Clamped load coinciding with tick; then clear+load together.
    ud = 1'b1;
    wait_tick();
    ld = 1'b1; lv = 8'hFA;
    cyc(1);
    ld = 1'b0;
    check("clamp_out", 32'(out4), 32'h99);
    check("clamp_carry", 32'(carry4), 32'd0);
    cyc(3);
    check("step_discarded", 32'(out4), 32'h99);
    check("tick_after_load", 32'(tick4), 32'd1);
    clr = 1'b1; ld = 1'b1; lv = 8'h55;
    cyc(1);
    clr = 1'b0; ld = 1'b0;
    check("clr_ld_out", 32'(out4), 32'h00);
    cyc(3);
    check("clr_presc_restart", 32'(tick4), 32'd1);

    // Freeze with enable low at prescaler = 2.
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(2);
    check("p1_two_steps", 32'(out1), 32'h02);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("frozen_tick", 32'(tick4), 32'd0);
      check("frozen_out", 32'(out4), 32'h00);
    end
    en = 1'b1;
    cyc(1);
    check("reen_tick", 32'(tick4), 32'd1);
    check("reen_out", 32'(out4), 32'h00);
    cyc(1);
    check("reen_step", 32'(out4), 32'h01);

    // Limit behaviour: saturating or wrapping depending on build.
    ld = 1'b1; lv = 8'h98;
    cyc(1);
    ld = 1'b0; ud = 1'b1;
    to_step();
    check("lim_up1_out", 32'(out4), 32'h99);
    check("lim_up1_carry", 32'(carry4), SAT ? 32'd1 : 32'd0);
    to_step();
    check("lim_up2_out", 32'(out4), SAT ? 32'h99 : 32'h00);
    check("lim_up2_carry", 32'(carry4), SAT ? 32'd0 : 32'd1);
    to_step();
    check("lim_up3_out", 32'(out4), SAT ? 32'h99 : 32'h01);
    check("lim_up3_carry", 32'(carry4), 32'd0);
    ld = 1'b1; lv = 8'h01;
    cyc(1);
    ld = 1'b0; ud = 1'b0;
    to_step();
    check("lim_dn1_out", 32'(out4), 32'h00);
    check("lim_dn1_carry", 32'(carry4), SAT ? 32'd1 : 32'd0);
    to_step();
    check("lim_dn2_out", 32'(out4), SAT ? 32'h00 : 32'h99);
    check("lim_dn2_carry", 32'(carry4), SAT ? 32'd0 : 32'd1);

    cyc(4);
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
